frame_mem_arbiter: RTL and testbench

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

---
 rtl/frame_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_frame_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter
// Shares one single-port frame-buffer RAM between the display (VGA painter) read
// port and the filter engine read/write port. The display has fixed priority.
// At most one RAM access is issued per cycle. Read data returns two cycles after
// the issue edge and is routed to its owner by a two-stage owner tag pipeline.
//
// Ports:
//   clk, rst                  single rising-edge clock, async active-high reset
//   disp_req/disp_addr        display read request and address
//   disp_data/disp_valid      display read data, one-cycle valid pulse per read
//   filt_req/filt_we          filter request, write (1) or read (0)
//   filt_addr/filt_wdata      filter address and write data
//   filt_gnt                  filter access accepted this cycle (combinational)
//   filt_rdata/filt_rvalid    filter read data, one-cycle valid pulse per read
//   filt_wait_max             longest filter wait observed, in cycles
//   mem_addr/mem_we/mem_wdata registered RAM command
//   mem_rdata                 RAM read data, one cycle after mem_addr registers
module frame_mem_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              filt_req,
    input  logic              filt_we,
    input  logic [ADDR_W-1:0] filt_addr,
    input  logic [DATA_W-1:0] filt_wdata,
    output logic              filt_gnt,
    output logic [DATA_W-1:0] filt_rdata,
    output logic              filt_rvalid,
    output logic [7:0]        filt_wait_max,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DISP    = 2'd1;
    localparam logic [1:0] FILT_RD = 2'd2;
    localparam logic [1:0] FILT_WR = 2'd3;

    // state is the owner of the access issued on the last edge (tag stage 1);
    // rd_tag is that owner one cycle later (tag stage 2), when mem_rdata is valid.
    logic [1:0] state;
    logic [1:0] next_state;
    logic [1:0] rd_tag;
    logic [7:0] wait_cnt;
    logic       waiting;

    assign filt_gnt = filt_req & ~disp_req & ~rst;
    assign waiting  = filt_req & ~filt_gnt;

    always_comb begin
        next_state = IDLE;
        if (disp_req) begin
            next_state = DISP;
        end else if (filt_req) begin
            next_state = filt_we ? FILT_WR : FILT_RD;
        end
    end

    // Issue stage: register the winner's command into the RAM port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            state <= next_state;
            unique case (next_state)
                DISP: begin
                    mem_addr <= disp_addr;
                    mem_we   <= 1'b0;
                end
                FILT_RD: begin
                    mem_addr <= filt_addr;
                    mem_we   <= 1'b0;
                end
                FILT_WR: begin
                    mem_addr  <= filt_addr;
                    mem_we    <= 1'b1;
                    mem_wdata <= filt_wdata;
                end
                default: begin
                    // Idle: address and data hold, only the write strobe drops.
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Return stage: route RAM data to its owner; data holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag      <= IDLE;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
            filt_rdata  <= '0;
            filt_rvalid <= 1'b0;
        end else begin
            rd_tag      <= state;
            disp_valid  <= (rd_tag == DISP);
            filt_rvalid <= (rd_tag == FILT_RD);
            if (rd_tag == DISP) begin
                disp_data <= mem_rdata;
            end
            if (rd_tag == FILT_RD) begin
                filt_rdata <= mem_rdata;
            end
        end
    end

    // Filter wait statistics. The max tracks the registered counter, so it
    // catches up one edge after the counter (including on the grant edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt      <= 8'd0;
            filt_wait_max <= 8'd0;
        end else begin
            if (filt_gnt) begin
                wait_cnt <= 8'd0;
            end else if (waiting && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_cnt > filt_wait_max) begin
                filt_wait_max <= wait_cnt;
            end
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
module tb_frame_mem_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              filt_req = 1'b0;
    logic              filt_we = 1'b0;
    logic [ADDR_W-1:0] filt_addr = '0;
    logic [DATA_W-1:0] filt_wdata = '0;
    logic              filt_gnt;
    logic [DATA_W-1:0] filt_rdata;
    logic              filt_rvalid;
    logic [7:0]        filt_wait_max;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    frame_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .filt_req     (filt_req),
        .filt_we      (filt_we),
        .filt_addr    (filt_addr),
        .filt_wdata   (filt_wdata),
        .filt_gnt     (filt_gnt),
        .filt_rdata   (filt_rdata),
        .filt_rvalid  (filt_rvalid),
        .filt_wait_max(filt_wait_max),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       dq[$];
    exp_t       fq[$];
    logic [7:0] shadow [int];
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] pattern(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[18:11] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] expected(input logic [ADDR_W-1:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return pattern(a);
    endfunction

    // Single-port RAM: read data one cycle after the address is registered.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = pattern(ADDR_W'(i));
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sets the inputs for one issue edge, records the expected outcome, then
    // advances to 1 time unit after that edge.
    task automatic drive(input logic dr, input logic [ADDR_W-1:0] da, input logic fr,
                         input logic fw, input logic [ADDR_W-1:0] fa,
                         input logic [7:0] fd, input bit push);
        exp_t e;
        disp_req   = dr;
        disp_addr  = da;
        filt_req   = fr;
        filt_we    = fw;
        filt_addr  = fa;
        filt_wdata = fd;
        if (push) begin
            if (dr) begin
                e.data = expected(da);
                e.due  = cyc + 3;
                dq.push_back(e);
            end else if (fr && fw) begin
                shadow[int'(fa)] = fd;
            end else if (fr) begin
                e.data = expected(fa);
                e.due  = cyc + 3;
                fq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, 8'h00, 1'b1);
    endtask

    // Monitor: pops the scoreboard whenever a valid is presented.
    initial begin
        exp_t       e;
        logic [7:0] last_disp;
        logic [7:0] last_filt;
        last_disp = 8'h00;
        last_filt = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_disp = 8'h00;
                last_filt = 8'h00;
            end else begin
                if (disp_valid) begin
                    if (dq.size() == 0) begin
                        check("disp_unexpected_pulse", 32'(disp_valid), 32'd0);
                    end else begin
                        e = dq.pop_front();
                        check("disp_data", 32'(disp_data), 32'(e.data));
                        check("disp_latency", 32'(cyc), 32'(e.due));
                        last_disp = e.data;
                    end
                end else begin
                    check("disp_data_hold", 32'(disp_data), 32'(last_disp));
                    if (dq.size() != 0 && dq[0].due <= cyc) begin
                        e = dq.pop_front();
                        check("disp_missed_pulse", 32'(disp_valid), 32'd1);
                    end
                end
                if (filt_rvalid) begin
                    if (fq.size() == 0) begin
                        check("filt_unexpected_pulse", 32'(filt_rvalid), 32'd0);
                    end else begin
                        e = fq.pop_front();
                        check("filt_rdata", 32'(filt_rdata), 32'(e.data));
                        check("filt_latency", 32'(cyc), 32'(e.due));
                        last_filt = e.data;
                    end
                end else begin
                    check("filt_rdata_hold", 32'(filt_rdata), 32'(last_filt));
                    if (fq.size() != 0 && fq[0].due <= cyc) begin
                        e = fq.pop_front();
                        check("filt_missed_pulse", 32'(filt_rvalid), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        check({tag, "_disp_data"}, 32'(disp_data), 32'd0);
        check({tag, "_filt_rvalid"}, 32'(filt_rvalid), 32'd0);
        check({tag, "_filt_rdata"}, 32'(filt_rdata), 32'd0);
        check({tag, "_filt_gnt"}, 32'(filt_gnt), 32'd0);
        check({tag, "_wait_max"}, 32'(filt_wait_max), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        // Reset state, with filt_req high to show the grant is suppressed.
        filt_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        filt_req = 1'b0;
        rst = 1'b0;
        idle(2);

        // Display only: 64 consecutive reads, one result per cycle.
        for (int i = 40; i <= 103; i++) drive(1'b1, ADDR_W'(i), 1'b0, 1'b0, '0, 8'h00, 1'b1);
        idle(4);

        // Contention: filter write blocked for 10 cycles behind the display.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ADDR_W'(200 + i), 1'b1, 1'b1, ADDR_W'(9), 8'h77, 1'b1);
            check("contention_gnt", 32'(filt_gnt), 32'd0);
            check("contention_mem_we", 32'(mem_we), 32'd0);
        end
        drive(1'b0, '0, 1'b1, 1'b1, ADDR_W'(9), 8'h77, 1'b1);
        check("contention_grant", 32'(filt_gnt), 32'd1);
        check("contention_wait_max", 32'(filt_wait_max), 32'd10);
        check("contention_write_we", 32'(mem_we), 32'd1);
        idle(4);

        // Write 0xA5 to address 5, read it back on the next cycle.
        drive(1'b0, '0, 1'b1, 1'b1, ADDR_W'(5), 8'hA5, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, ADDR_W'(5), 8'h00, 1'b1);
        idle(4);
        check("wr_rd_shadow", 32'(expected(ADDR_W'(5))), 32'h0A5);

        // Interleave display and filter reads every cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ADDR_W'(300 + i), 1'b0, 1'b0, '0, 8'h00, 1'b1);
            drive(1'b0, '0, 1'b1, 1'b0, ADDR_W'(1000 + 3 * i), 8'h00, 1'b1);
        end
        idle(4);

        // Top address passes through unmodified; idle holds the address.
        drive(1'b0, '0, 1'b1, 1'b1, 19'h7FFFF, 8'h3C, 1'b1);
        check("top_write_addr", 32'(mem_addr), 32'h7FFFF);
        check("top_write_we", 32'(mem_we), 32'd1);
        check("top_write_data", 32'(mem_wdata), 32'h3C);
        drive(1'b0, '0, 1'b1, 1'b0, 19'h7FFFF, 8'h00, 1'b1);
        check("top_read_we", 32'(mem_we), 32'd0);
        idle(1);
        check("idle_addr_hold", 32'(mem_addr), 32'h7FFFF);
        check("idle_we", 32'(mem_we), 32'd0);
        idle(4);

        // Reset one cycle after a display read issues: the read is discarded.
        drive(1'b1, ADDR_W'(77), 1'b0, 1'b0, '0, 8'h00, 1'b0);
        disp_req = 1'b0;
        filt_req = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midread");
        @(posedge clk);
        #1;
        filt_req = 1'b0;
        rst = 1'b0;
        idle(6);

        // Saturation: filter read blocked for 300 cycles.
        for (int i = 0; i < 300; i++)
            drive(1'b1, ADDR_W'(i), 1'b1, 1'b0, ADDR_W'(2000), 8'h00, 1'b1);
        check("sat_blocked_gnt", 32'(filt_gnt), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0, ADDR_W'(2000), 8'h00, 1'b1);
        check("sat_wait_max", 32'(filt_wait_max), 32'd255);
        idle(6);

        check("disp_queue_drained", 32'(dq.size()), 32'd0);
        check("filt_queue_drained", 32'(fq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
